// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM geometry, opcode field and fetch FSM states.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 27;
  localparam int OP_MSB = 26;
  localparam int OP_LSB = 23;
  localparam logic [OP_MSB-OP_LSB:0] HALT_OP = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, addresses the external microcode
// ROM, registers each word and offers it to decode over valid/ready.
module cpu_fetch_seq #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1),
  parameter logic [3:0]        HALT_OP  = cpu_pkg::HALT_OP,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  import cpu_pkg::*;

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic              valid_nx;
  logic [DATA_W-1:0] data_nx;
  logic [ADDR_W-1:0] ipc_nx;
  logic [CNT_W-1:0]  count_nx;

  logic accept;   // decode takes the held word this edge
  logic cap;      // output register is free to take a new word
  logic is_halt;  // word on the ROM bus carries the HALT opcode
  logic flush;    // redirect actually takes effect this edge

  assign rom_addr = pc;
  assign busy     = (state == FETCH);
  assign halted   = (state == HALTED);

  assign accept  = instr_valid && instr_ready;
  assign cap     = !instr_valid || instr_ready;
  assign is_halt = (rom_data[OP_MSB:OP_LSB] == HALT_OP);
  assign flush   = redirect_valid && (state != IDLE);

  // Next-state, PC and output-register selection.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    valid_nx = instr_valid;
    data_nx  = instr_data;
    ipc_nx   = instr_pc;
    count_nx = fetch_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FETCH;
          pc_nx    = RESET_PC;
        end
      end
      FETCH: begin
        // A redirect squashes both the held word and this cycle's fetch.
        if (redirect_valid) begin
          pc_nx    = redirect_addr;
          valid_nx = 1'b0;
        end else if (cap) begin
          data_nx  = rom_data;
          ipc_nx   = pc;
          valid_nx = 1'b1;
          if (is_halt) begin
            state_nx = HALTED;
          end else begin
            pc_nx = pc + 1'b1;
          end
        end
      end
      HALTED: begin
        // Redirect has priority over start when both arrive together.
        if (redirect_valid) begin
          state_nx = FETCH;
          pc_nx    = redirect_addr;
          valid_nx = 1'b0;
        end else if (start) begin
          state_nx = FETCH;
          pc_nx    = RESET_PC;
          valid_nx = 1'b0;
        end else if (accept) begin
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        pc_nx    = RESET_PC;
        valid_nx = 1'b0;
      end
    endcase

    // Count only words that decode really keeps; saturate at all-ones.
    if (accept && !flush && !(&fetch_count)) begin
      count_nx = fetch_count + 1'b1;
    end
  end

  // State, PC, output word and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_valid <= valid_nx;
      instr_data  <= data_nx;
      instr_pc    <= ipc_nx;
      fetch_count <= count_nx;
    end
  end

endmodule
